// File: rtl/tmr_err_monitor.sv
// Error-episode monitor for a triplicated design: edge-counts voter mismatches and queues event records.
// Define TMR_ERR_MON_TIMESTAMP_EN to build the free-running timestamp and per-record time storage.
module tmr_err_monitor #(
    parameter int CNT_W  = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 4,
    parameter int THRESH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            err,
    input  logic            clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic            err_seen,
    output logic            alarm,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W-1:0] evt_time,
    output logic            evt_ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic             err_d;
    logic             evt;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign evt  = err & ~err_d;
    assign full = (occ == OCC_FULL);
    assign pop  = evt_valid & evt_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push = evt & ~clr & (~full | pop);
    assign drop = evt & ~clr & full & ~pop;

    assign evt_valid = (occ != '0);
    assign alarm     = (err_cnt >= CNT_W'(THRESH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_d    <= 1'b0;
            err_cnt  <= '0;
            err_seen <= 1'b0;
            evt_ovf  <= 1'b0;
            occ      <= '0;
        end else begin
            // err_d tracks err even under clr so a held level is not recounted.
            err_d <= err;
            if (clr) begin
                err_cnt  <= '0;
                err_seen <= 1'b0;
                evt_ovf  <= 1'b0;
                occ      <= '0;
            end else begin
                if (evt) begin
                    err_cnt  <= sat_inc(err_cnt);
                    err_seen <= 1'b1;
                end
                if (drop) begin
                    evt_ovf <= 1'b1;
                end
                case ({push, pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

`ifdef TMR_ERR_MON_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            ts <= ts + TS_W'(1);
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Record storage carries no reset; evt_time is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ts;
    end

    assign evt_time = evt_valid ? mem[rd_ptr] : '0;
`else
    assign evt_time = '0;
`endif

endmodule
